// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC hit sequencer: default sizes, FSM encoding and
// the timestamp record.
package tdc_pkg;

    localparam int TDC_TAPS     = 32;
    localparam int TDC_BIN_W    = 6;
    localparam int TDC_COARSE_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_ENCODE = 3'd2;
    localparam logic [2:0] ST_OUTPUT = 3'd3;
    localparam logic [2:0] ST_DEAD   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ARMED  = ST_ARMED,
        S_ENCODE = ST_ENCODE,
        S_OUTPUT = ST_OUTPUT,
        S_DEAD   = ST_DEAD
    } tdc_state_e;

    typedef struct packed {
        logic [TDC_COARSE_W-1:0] coarse;
        logic [TDC_BIN_W-1:0]    fine;
        logic                    err;
    } tdc_ts_t;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Free-running coarse time counter for one TDC channel, with a one-cycle pulse
// in the cycle it reads zero after rolling over.
module tdc_coarse_counter
    import tdc_pkg::*;
#(
    parameter int COARSE_W = TDC_COARSE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic                i_clear,
    output logic [COARSE_W-1:0] o_count,
    output logic                o_wrap
);

    logic [COARSE_W-1:0] r_count;
    logic                r_wrap;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (i_enable) begin
            r_count <= r_count + COARSE_W'(1);
            r_wrap  <= &r_count;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/tdc_hit_sequencer.sv
// Per-channel TDC sequencer: captures the delay-line snapshot on a hit, waits for
// the encoder, and hands a {coarse, fine, err} timestamp to the readout FIFO.
module tdc_hit_sequencer
    import tdc_pkg::*;
#(
    parameter int TAPS        = TDC_TAPS,
    parameter int BIN_W       = TDC_BIN_W,
    parameter int COARSE_W    = TDC_COARSE_W,
    parameter int ENC_LAT     = 1,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                disarm,
    input  logic                hit_det,
    input  logic [TAPS-1:0]     thermo_snap,
    output logic [TAPS-1:0]     enc_thermo,
    input  logic [BIN_W-1:0]    enc_bin,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [BIN_W-1:0]    ts_fine,
    output logic                ts_err,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic                coarse_wrap,
    output logic [7:0]          lost_cnt,
    output logic                busy
);

    localparam int                 LAT_W     = 2;
    localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(ENC_LAT - 1);
    localparam int                 DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    tdc_state_e          r_state;
    tdc_state_e          w_state_next;
    logic [LAT_W-1:0]    r_lat;
    logic [DEAD_W-1:0]   r_dead;
    logic                r_disarm_pend;
    logic [TAPS-1:0]     r_enc_thermo;
    logic [COARSE_W-1:0] r_ts_coarse;
    logic [BIN_W-1:0]    r_ts_fine;
    logic                r_ts_err;
    logic                r_ts_valid;
    logic [7:0]          r_lost_cnt;
    logic [COARSE_W-1:0] w_count;
    logic                w_wrap;
    logic                w_disarm_req;
    logic                w_hit_lost;

    tdc_coarse_counter #(
        .COARSE_W (COARSE_W)
    ) u_coarse (
        .clk      (clk),
        .rst      (rst),
        .i_enable (r_state != S_IDLE),
        .i_clear  (w_state_next == S_IDLE),
        .o_count  (w_count),
        .o_wrap   (w_wrap)
    );

    // A disarm seen during the accept cycle itself counts as pending.
    assign w_disarm_req = r_disarm_pend | disarm;
    assign w_hit_lost   = hit_det &&
                          (r_state == S_ENCODE || r_state == S_OUTPUT || r_state == S_DEAD);

    always_comb begin
        // NOTE: default assigned first so no branch leaves the signal unassigned and infers a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (arm && !disarm) w_state_next = S_ARMED;
            S_ARMED:  if (disarm) w_state_next = S_IDLE;
                      else if (hit_det) w_state_next = S_ENCODE;
            S_ENCODE: if (r_lat == LAT_LAST) w_state_next = S_OUTPUT;
            S_OUTPUT: if (ts_ready) begin
                          if (w_disarm_req)          w_state_next = S_IDLE;
                          else if (DEAD_CYCLES == 0) w_state_next = S_ARMED;
                          else                       w_state_next = S_DEAD;
                      end
            S_DEAD:   if (disarm) w_state_next = S_IDLE;
                      else if (r_dead == DEAD_LAST) w_state_next = S_ARMED;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lat         <= '0;
            r_dead        <= '0;
            r_disarm_pend <= 1'b0;
            r_enc_thermo  <= '0;
            r_ts_coarse   <= '0;
            r_ts_fine     <= '0;
            r_ts_err      <= 1'b0;
            r_ts_valid    <= 1'b0;
            r_lost_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            r_lat   <= (r_state == S_ENCODE) ? r_lat + LAT_W'(1) : '0;
            r_dead  <= (r_state == S_DEAD) ? r_dead + DEAD_W'(1) : '0;

            if (r_state == S_ARMED && w_state_next == S_ENCODE) begin
                r_enc_thermo <= thermo_snap;
                r_ts_coarse  <= w_count;
            end

            if (r_state == S_ENCODE && w_state_next == S_OUTPUT) begin
                r_ts_fine  <= enc_bin;
                r_ts_err   <= (enc_bin == '0);
                r_ts_valid <= 1'b1;
            end else if (r_state == S_OUTPUT && ts_ready) begin
                r_ts_valid <= 1'b0;
            end

            if (r_state == S_ENCODE || r_state == S_OUTPUT) begin
                if (disarm) r_disarm_pend <= 1'b1;
            end else begin
                r_disarm_pend <= 1'b0;
            end

            if (w_hit_lost && r_lost_cnt != 8'hFF) r_lost_cnt <= r_lost_cnt + 8'd1;
        end
    end

    assign enc_thermo  = r_enc_thermo;
    assign ts_coarse   = r_ts_coarse;
    assign ts_fine     = r_ts_fine;
    assign ts_err      = r_ts_err;
    assign ts_valid    = r_ts_valid;
    assign coarse_wrap = w_wrap;
    assign lost_cnt    = r_lost_cnt;
    assign busy        = (r_state != S_IDLE) && (r_state != S_ARMED);

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Directed bench for tdc_hit_sequencer: a cycle-by-cycle vector table on the
// default-size instance plus hand sequences for lost-hit saturation and wrap.
module tb_tdc_hit_sequencer;
    import tdc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, arm, disarm, hit_det, ts_ready;
    logic [31:0] thermo_snap;

    logic [31:0] enc_thermo, enc_thermo4;
    logic [5:0]  enc_bin, enc_bin4;
    logic [15:0] ts_coarse;
    logic [3:0]  ts_coarse4;
    logic [5:0]  ts_fine, ts_fine4;
    logic        ts_err, ts_err4, ts_valid, ts_valid4;
    logic        coarse_wrap, coarse_wrap4, busy, busy4;
    logic [7:0]  lost_cnt, lost_cnt4;

    always #5 clk = ~clk;

    // Thermometer encoder model: bin = number of set taps.
    assign enc_bin  = 6'($countones(enc_thermo));
    assign enc_bin4 = 6'($countones(enc_thermo4));

    tdc_hit_sequencer #(.TAPS(32), .BIN_W(6), .COARSE_W(16), .ENC_LAT(1), .DEAD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .hit_det(hit_det),
        .thermo_snap(thermo_snap), .enc_thermo(enc_thermo), .enc_bin(enc_bin),
        .ts_coarse(ts_coarse), .ts_fine(ts_fine), .ts_err(ts_err), .ts_valid(ts_valid),
        .ts_ready(ts_ready), .coarse_wrap(coarse_wrap), .lost_cnt(lost_cnt), .busy(busy)
    );

    tdc_hit_sequencer #(.TAPS(32), .BIN_W(6), .COARSE_W(4), .ENC_LAT(1), .DEAD_CYCLES(2)) dut4 (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .hit_det(hit_det),
        .thermo_snap(thermo_snap), .enc_thermo(enc_thermo4), .enc_bin(enc_bin4),
        .ts_coarse(ts_coarse4), .ts_fine(ts_fine4), .ts_err(ts_err4), .ts_valid(ts_valid4),
        .ts_ready(ts_ready), .coarse_wrap(coarse_wrap4), .lost_cnt(lost_cnt4), .busy(busy4)
    );

    typedef struct {
        logic        rst, arm, disarm, hit;
        logic [31:0] snap;
        logic        ready;
        logic        e_valid, e_busy;
        tdc_ts_t     e_ts;
        logic [7:0]  e_lost;
        logic [31:0] e_thermo;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic r, input logic a, input logic d, input logic h,
                       input logic [31:0] s, input logic rd,
                       input logic v, input logic b, input logic [15:0] c,
                       input logic [5:0] f, input logic e, input logic [7:0] l,
                       input logic [31:0] t);
        vec_t x;
        x.rst = r; x.arm = a; x.disarm = d; x.hit = h; x.snap = s; x.ready = rd;
        x.e_valid = v; x.e_busy = b;
        x.e_ts.coarse = c; x.e_ts.fine = f; x.e_ts.err = e;
        x.e_lost = l; x.e_thermo = t;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; hit_det = 1'b0; ts_ready = 1'b0;
        thermo_snap = '0;

        //   rst arm dis hit snap          rdy | vld bsy coarse fine err lost thermo
        add(1, 0, 0, 0, 32'h0,          0,   0, 0, 16'd0,  6'd0,  0, 8'd0, 32'h0);   // reset
        add(0, 1, 0, 0, 32'h0,          0,   0, 0, 16'd0,  6'd0,  0, 8'd0, 32'h0);   // arm, cnt=0
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 32'h0,      0,   0, 0, 16'd0,  6'd0,  0, 8'd0, 32'h0);   // cnt -> 5
        add(0, 0, 0, 1, 32'h0000_00FF,  1,   0, 1, 16'd5,  6'd0,  0, 8'd0, 32'hFF);  // hit at 5
        add(0, 0, 0, 0, 32'h0,          1,   1, 1, 16'd5,  6'd8,  0, 8'd0, 32'hFF);  // valid
        add(0, 0, 0, 0, 32'h0,          1,   0, 1, 16'd5,  6'd8,  0, 8'd0, 32'hFF);  // accepted -> DEAD
        add(0, 0, 0, 0, 32'h0,          0,   0, 1, 16'd5,  6'd8,  0, 8'd0, 32'hFF);  // DEAD 2
        add(0, 0, 0, 0, 32'h0,          0,   0, 0, 16'd5,  6'd8,  0, 8'd0, 32'hFF);  // ARMED, cnt 10
        add(0, 0, 0, 1, 32'h0000_0FFF,  0,   0, 1, 16'd10, 6'd8,  0, 8'd0, 32'hFFF); // hit at 10
        add(0, 0, 0, 0, 32'h0,          0,   1, 1, 16'd10, 6'd12, 0, 8'd0, 32'hFFF);
        for (int i = 0; i < 10; i++) begin                                           // backpressure
            logic       h;
            logic [7:0] l;
            h = (i == 1 || i == 4 || i == 7);
            l = (i >= 7) ? 8'd3 : (i >= 4) ? 8'd2 : (i >= 1) ? 8'd1 : 8'd0;
            add(0, 0, 0, h, 32'hFFFF_FFFF, 0, 1, 1, 16'd10, 6'd12, 0, l, 32'hFFF);
        end
        add(0, 0, 0, 0, 32'h0,          1,   0, 1, 16'd10, 6'd12, 0, 8'd3, 32'hFFF); // accept
        add(0, 0, 0, 0, 32'h0,          0,   0, 1, 16'd10, 6'd12, 0, 8'd3, 32'hFFF);
        add(0, 0, 0, 0, 32'h0,          0,   0, 0, 16'd10, 6'd12, 0, 8'd3, 32'hFFF); // ARMED, cnt 25
        add(0, 0, 0, 1, 32'h0,          1,   0, 1, 16'd25, 6'd12, 0, 8'd3, 32'h0);   // empty snapshot
        add(0, 0, 0, 0, 32'h0,          1,   1, 1, 16'd25, 6'd0,  1, 8'd3, 32'h0);   // err flagged
        add(0, 0, 0, 0, 32'h0,          1,   0, 1, 16'd25, 6'd0,  1, 8'd3, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0,   0, 1, 16'd25, 6'd0,  1, 8'd3, 32'h0);
        add(0, 0, 0, 0, 32'h0,          0,   0, 0, 16'd25, 6'd0,  1, 8'd3, 32'h0);   // ARMED, cnt 30
        add(0, 0, 0, 1, 32'h0000_0007,  0,   0, 1, 16'd30, 6'd0,  1, 8'd3, 32'h7);   // hit at 30
        add(0, 0, 1, 0, 32'h0,          0,   1, 1, 16'd30, 6'd3,  0, 8'd3, 32'h7);   // disarm in ENCODE
        add(0, 0, 0, 0, 32'h0,          0,   1, 1, 16'd30, 6'd3,  0, 8'd3, 32'h7);
        add(0, 0, 0, 0, 32'h0,          1,   0, 0, 16'd30, 6'd3,  0, 8'd3, 32'h7);   // accept -> IDLE
        add(0, 0, 0, 1, 32'h0000_000F,  0,   0, 0, 16'd30, 6'd3,  0, 8'd3, 32'h7);   // hit ignored
        add(0, 0, 0, 0, 32'h0,          0,   0, 0, 16'd30, 6'd3,  0, 8'd3, 32'h7);
        add(0, 1, 0, 0, 32'h0,          0,   0, 0, 16'd30, 6'd3,  0, 8'd3, 32'h7);   // re-arm, cnt 0
        add(0, 1, 0, 1, 32'h0000_0001,  0,   0, 1, 16'd0,  6'd3,  0, 8'd3, 32'h1);   // hit at 0
        add(0, 0, 0, 0, 32'h0,          0,   1, 1, 16'd0,  6'd1,  0, 8'd3, 32'h1);
        add(1, 0, 0, 0, 32'h0,          0,   0, 0, 16'd0,  6'd0,  0, 8'd0, 32'h0);   // reset in OUTPUT
        add(0, 1, 1, 0, 32'h0,          0,   0, 0, 16'd0,  6'd0,  0, 8'd0, 32'h0);   // arm+disarm
        add(0, 0, 0, 1, 32'h0000_000F,  0,   0, 0, 16'd0,  6'd0,  0, 8'd0, 32'h0);   // still IDLE

        foreach (vecs[i]) begin
            rst = vecs[i].rst; arm = vecs[i].arm; disarm = vecs[i].disarm;
            hit_det = vecs[i].hit; thermo_snap = vecs[i].snap; ts_ready = vecs[i].ready;
            tick();
            check($sformatf("row%0d ts_valid", i),    32'(ts_valid),    32'(vecs[i].e_valid));
            check($sformatf("row%0d busy", i),        32'(busy),        32'(vecs[i].e_busy));
            check($sformatf("row%0d ts_coarse", i),   32'(ts_coarse),   32'(vecs[i].e_ts.coarse));
            check($sformatf("row%0d ts_fine", i),     32'(ts_fine),     32'(vecs[i].e_ts.fine));
            check($sformatf("row%0d ts_err", i),      32'(ts_err),      32'(vecs[i].e_ts.err));
            check($sformatf("row%0d lost_cnt", i),    32'(lost_cnt),    32'(vecs[i].e_lost));
            check($sformatf("row%0d enc_thermo", i),  enc_thermo,       vecs[i].e_thermo);
            check($sformatf("row%0d coarse_wrap", i), 32'(coarse_wrap), 32'd0);
        end

        // Lost-hit counter saturates at 255 while a timestamp is held.
        rst = 1'b0; arm = 1'b1; disarm = 1'b0; hit_det = 1'b0; ts_ready = 1'b0;
        tick();
        arm = 1'b0; hit_det = 1'b1; thermo_snap = 32'h3;
        tick();
        hit_det = 1'b0;
        tick();
        check("sat ts_valid before", 32'(ts_valid), 32'd1);
        hit_det = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        check("sat lost_cnt", 32'(lost_cnt), 32'd255);
        check("sat ts_fine held", 32'(ts_fine), 32'd2);
        check("sat ts_valid held", 32'(ts_valid), 32'd1);
        hit_det = 1'b0; ts_ready = 1'b1;
        tick();
        check("sat accept ts_valid", 32'(ts_valid), 32'd0);
        check("sat lost_cnt after", 32'(lost_cnt), 32'd255);

        // 4-bit coarse counter wraps after 16 cycles; the next hit sees coarse=1.
        rst = 1'b1; ts_ready = 1'b0;
        tick();
        rst = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("wrap4 cycle%0d", k), 32'(coarse_wrap4), 32'(k == 16));
            check($sformatf("wrap16 cycle%0d", k), 32'(coarse_wrap), 32'd0);
        end
        hit_det = 1'b1; thermo_snap = 32'h0000_003F;
        tick();
        hit_det = 1'b0;
        tick();
        check("wrap4 ts_valid", 32'(ts_valid4), 32'd1);
        check("wrap4 ts_coarse", 32'(ts_coarse4), 32'd1);
        check("wrap4 ts_fine", 32'(ts_fine4), 32'd6);
        check("wrap16 ts_coarse", 32'(ts_coarse), 32'd17);
        ts_ready = 1'b1;
        tick();
        check("wrap4 accept ts_valid", 32'(ts_valid4), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
